// File: rtl/cond_exec_unit.sv
// Conditional-execution unit for the execute stage.
// Evaluates the instruction's condition field against the architectural
// flags, gates the side-effecting controls, owns the {N,Z,C,V} register and
// keeps saturating counts of executed and condition-failed instructions.
module cond_exec_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ValidE,
    input  logic        FlushE,
    input  logic [3:0]  CondE,
    input  logic [1:0]  FlagWriteE,
    input  logic [3:0]  ALUFlags,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        BranchE,
    input  logic        ClrCnt,
    output logic        CondExE,
    output logic        PCSrcG,
    output logic        RegWriteG,
    output logic        MemWriteG,
    output logic        BranchTakenG,
    output logic [3:0]  Flags,
    output logic [15:0] ExecCount,
    output logic [15:0] SquashCount
);

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic  flag_n;
    logic  flag_z;
    logic  flag_c;
    logic  flag_v;
    logic  cond_pass;
    logic  live;
    logic  squash;
    cond_t cond;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];
    assign cond   = cond_t'(CondE);

    // Condition check always uses the registered (pre-update) flags; no bypass.
    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = !flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = !flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = !flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = !flag_v;
            COND_HI: cond_pass = flag_c & !flag_z;
            COND_LS: cond_pass = !flag_c | flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = !flag_z & (flag_n == flag_v);
            COND_LE: cond_pass = flag_z | (flag_n != flag_v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b1;
            default: cond_pass = 1'b1;
        endcase
    end

    // A live instruction is real and not squashed; it either executes or fails its condition.
    always_comb begin
        live         = ValidE & !FlushE;
        CondExE      = live & cond_pass;
        squash       = live & !cond_pass;
        PCSrcG       = PCSrcE    & CondExE;
        RegWriteG    = RegWriteE & CondExE;
        MemWriteG    = MemWriteE & CondExE;
        BranchTakenG = BranchE   & CondExE;
    end

    // Flag register: N,Z and C,V pairs are written independently by executed instructions.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Flags <= 4'b0000;
        end else begin
            if (CondExE && FlagWriteE[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (CondExE && FlagWriteE[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Executed-instruction counter; clear beats increment, saturates instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ExecCount <= 16'd0;
        end else if (ClrCnt) begin
            ExecCount <= 16'd0;
        end else if (CondExE && (ExecCount != COUNT_MAX)) begin
            ExecCount <= ExecCount + 16'd1;
        end
    end

    // Condition-failed counter; same clear and saturation rules as the executed counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SquashCount <= 16'd0;
        end else if (ClrCnt) begin
            SquashCount <= 16'd0;
        end else if (squash && (SquashCount != COUNT_MAX)) begin
            SquashCount <= SquashCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed self-checking bench for cond_exec_unit.
module tb_cond_exec_unit;

    logic        CLK;
    logic        RST;
    logic        ValidE;
    logic        FlushE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [3:0]  ALUFlags;
    logic        PCSrcE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        BranchE;
    logic        ClrCnt;
    logic        CondExE;
    logic        PCSrcG;
    logic        RegWriteG;
    logic        MemWriteG;
    logic        BranchTakenG;
    logic [3:0]  Flags;
    logic [15:0] ExecCount;
    logic [15:0] SquashCount;

    int          checks;
    int          failures;
    logic [15:0] exp_exec;
    logic [15:0] exp_squash;

    cond_exec_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .ValidE       (ValidE),
        .FlushE       (FlushE),
        .CondE        (CondE),
        .FlagWriteE   (FlagWriteE),
        .ALUFlags     (ALUFlags),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .BranchE      (BranchE),
        .ClrCnt       (ClrCnt),
        .CondExE      (CondExE),
        .PCSrcG       (PCSrcG),
        .RegWriteG    (RegWriteG),
        .MemWriteG    (MemWriteG),
        .BranchTakenG (BranchTakenG),
        .Flags        (Flags),
        .ExecCount    (ExecCount),
        .SquashCount  (SquashCount)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive a new instruction just after the falling edge, then let logic settle.
    task automatic applyStimulus(input logic v, input logic f, input logic [3:0] c,
                                 input logic [1:0] fw, input logic [3:0] alu,
                                 input logic pc, input logic rw, input logic mw,
                                 input logic br, input logic clr);
        @(negedge CLK);
        ValidE     = v;
        FlushE     = f;
        CondE      = c;
        FlagWriteE = fw;
        ALUFlags   = alu;
        PCSrcE     = pc;
        RegWriteE  = rw;
        MemWriteE  = mw;
        BranchE    = br;
        ClrCnt     = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One instruction: check gated outputs before the edge, registers after it.
    task automatic run_step(input string tag, input logic v, input logic f,
                            input logic [3:0] c, input logic [1:0] fw,
                            input logic [3:0] alu, input logic pc, input logic rw,
                            input logic mw, input logic br, input logic clr,
                            input logic exp_ce, input logic [3:0] exp_flags);
        applyStimulus(v, f, c, fw, alu, pc, rw, mw, br, clr);
        checkOutput({tag, ".CondExE"},      {15'd0, CondExE},      {15'd0, exp_ce});
        checkOutput({tag, ".PCSrcG"},       {15'd0, PCSrcG},       {15'd0, pc & exp_ce});
        checkOutput({tag, ".RegWriteG"},    {15'd0, RegWriteG},    {15'd0, rw & exp_ce});
        checkOutput({tag, ".MemWriteG"},    {15'd0, MemWriteG},    {15'd0, mw & exp_ce});
        checkOutput({tag, ".BranchTakenG"}, {15'd0, BranchTakenG}, {15'd0, br & exp_ce});
        tick();
        if (clr) begin
            exp_exec   = 16'd0;
            exp_squash = 16'd0;
        end else if (v && !f) begin
            if (exp_ce) begin
                if (exp_exec != 16'hFFFF) exp_exec = exp_exec + 16'd1;
            end else begin
                if (exp_squash != 16'hFFFF) exp_squash = exp_squash + 16'd1;
            end
        end
        checkOutput({tag, ".Flags"},       {12'd0, Flags}, {12'd0, exp_flags});
        checkOutput({tag, ".ExecCount"},   ExecCount,      exp_exec);
        checkOutput({tag, ".SquashCount"}, SquashCount,    exp_squash);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_exec   = 16'd0;
        exp_squash = 16'd0;
        RST        = 1'b1;
        ValidE     = 1'b0;
        FlushE     = 1'b0;
        CondE      = 4'h0;
        FlagWriteE = 2'b00;
        ALUFlags   = 4'h0;
        PCSrcE     = 1'b0;
        RegWriteE  = 1'b0;
        MemWriteE  = 1'b0;
        BranchE    = 1'b0;
        ClrCnt     = 1'b0;
        #2;
        checkOutput("reset.Flags",       {12'd0, Flags}, 16'd0);
        checkOutput("reset.ExecCount",   ExecCount,      16'd0);
        checkOutput("reset.SquashCount", SquashCount,    16'd0);

        // Held in reset: combinational path works against Flags=0, state stays cleared
        applyStimulus(1, 0, 4'h1, 2'b11, 4'hF, 0, 1, 0, 0, 0);
        checkOutput("rst_ne.CondExE",   {15'd0, CondExE},   16'd1);
        checkOutput("rst_ne.RegWriteG", {15'd0, RegWriteG}, 16'd1);
        tick();
        checkOutput("rst_ne.Flags",     {12'd0, Flags}, 16'd0);
        checkOutput("rst_ne.ExecCount", ExecCount,      16'd0);
        applyStimulus(1, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        checkOutput("rst_eq.CondExE", {15'd0, CondExE}, 16'd0);
        applyStimulus(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        tick();

        // EQ fails on zero flags and is counted as squashed
        run_step("eq_fail",   1, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 4'b0000);
        // AL writes Z; the following EQ sees it and takes the branch
        run_step("al_setz",   1, 0, 4'hE, 2'b11, 4'b0100, 0, 1, 0, 0, 0, 1, 4'b0100);
        run_step("eq_branch", 1, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 1, 0, 1, 4'b0100);
        // NE evaluated on old Z=1 fails even though it carries new flags
        run_step("ne_nobyp",  1, 0, 4'h1, 2'b11, 4'b0000, 0, 1, 0, 0, 0, 0, 4'b0100);
        // Partial flag write: only C,V taken from the ALU
        run_step("al_1001",   1, 0, 4'hE, 2'b11, 4'b1001, 0, 0, 0, 0, 0, 1, 4'b1001);
        run_step("ge_cv",     1, 0, 4'hA, 2'b01, 4'b0110, 0, 1, 0, 0, 0, 1, 4'b1010);
        // Flush suppresses everything
        run_step("flush",     1, 1, 4'hE, 2'b11, 4'b0101, 1, 1, 1, 1, 0, 0, 4'b1010);
        // Bubble counts nowhere
        run_step("bubble",    0, 0, 4'hE, 2'b11, 4'b0000, 1, 1, 1, 1, 0, 0, 4'b1010);
        // Condition table sweep with N=1 Z=0 C=1 V=0
        run_step("lt",        1, 0, 4'hB, 2'b00, 4'h0, 1, 0, 0, 0, 0, 1, 4'b1010);
        run_step("gt",        1, 0, 4'hC, 2'b00, 4'h0, 1, 0, 0, 0, 0, 0, 4'b1010);
        run_step("hi",        1, 0, 4'h8, 2'b00, 4'h0, 0, 1, 0, 0, 0, 1, 4'b1010);
        run_step("ls",        1, 0, 4'h9, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 4'b1010);
        run_step("le",        1, 0, 4'hD, 2'b00, 4'h0, 0, 0, 1, 0, 0, 1, 4'b1010);
        run_step("vs",        1, 0, 4'h6, 2'b00, 4'h0, 0, 0, 0, 1, 0, 0, 4'b1010);
        run_step("cc",        1, 0, 4'h3, 2'b00, 4'h0, 0, 0, 0, 1, 0, 0, 4'b1010);
        run_step("mi",        1, 0, 4'h4, 2'b00, 4'h0, 0, 0, 0, 1, 0, 1, 4'b1010);
        run_step("pl",        1, 0, 4'h5, 2'b00, 4'h0, 0, 0, 0, 1, 0, 0, 4'b1010);
        run_step("cs",        1, 0, 4'h2, 2'b00, 4'h0, 0, 0, 0, 1, 0, 1, 4'b1010);
        run_step("vc",        1, 0, 4'h7, 2'b00, 4'h0, 0, 0, 0, 1, 0, 1, 4'b1010);
        run_step("nv",        1, 0, 4'hF, 2'b00, 4'h0, 0, 1, 0, 0, 0, 1, 4'b1010);
        run_step("al_1111",   1, 0, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 0, 0, 1, 4'b1111);

        // Asynchronous reset pulse between edges
        #1;
        RST = 1'b1;
        #1;
        checkOutput("midrst.Flags",       {12'd0, Flags}, 16'd0);
        checkOutput("midrst.ExecCount",   ExecCount,      16'd0);
        checkOutput("midrst.SquashCount", SquashCount,    16'd0);
        RST        = 1'b0;
        exp_exec   = 16'd0;
        exp_squash = 16'd0;

        run_step("post_ne",   1, 0, 4'h1, 2'b00, 4'h0, 0, 1, 0, 0, 0, 1, 4'b0000);
        run_step("post_eq",   1, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 4'b0000);

        // Fill the executed counter up to 0xFFFE
        for (int i = 0; i < 65533; i++) begin
            applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0);
            tick();
            exp_exec = exp_exec + 16'd1;
        end
        checkOutput("fill.ExecCount", ExecCount, 16'hFFFE);
        run_step("sat1",      1, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0, 1, 4'b0000);
        checkOutput("sat1.max", ExecCount, 16'hFFFF);
        run_step("sat2",      1, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0, 1, 4'b0000);
        checkOutput("sat2.hold", ExecCount, 16'hFFFF);
        // Clear wins over a simultaneous passing instruction
        run_step("clr",       1, 0, 4'hE, 2'b00, 4'h0, 0, 1, 0, 0, 1, 1, 4'b0000);
        checkOutput("clr.zero", ExecCount, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
